// File: rtl/spike_event_player_if.sv
// spike_event_player_if
//   Event-table write channel between a host and spike_event_player.
//   master : host side, drives wr_valid/wr_time/wr_row/wr_addr, samples wr_ready
//   slave  : player side, samples the write request, drives wr_ready
interface spike_event_player_if #(
  parameter int TIME_WIDTH = 16,
  parameter int ROW_W      = 1,
  parameter int ADDR_WIDTH = 6
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [TIME_WIDTH-1:0] wr_time;
  logic [ROW_W-1:0]      wr_row;
  logic [ADDR_WIDTH-1:0] wr_addr;

  modport master (
    output wr_valid, wr_time, wr_row, wr_addr,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_time, wr_row, wr_addr,
    output wr_ready
  );
endinterface

// File: rtl/spike_event_player.sv
// spike_event_player
//   Loads a table of time-stamped spike events (timestamp, row, address) and,
//   once started, replays each event on its row's one-cycle spike strobe when
//   the local timebase reaches its timestamp. Events issue in table order, at
//   most one per cycle; events issued after their timestamp are counted late.
//
// Ports
//   clk, reset_n  : clock, asynchronous active-low reset
//   clear         : synchronous table clear (ignored during playback)
//   wr            : event write channel (spike_event_player_if.slave)
//   start, stop   : begin / abort playback
//   loop_en       : replay the table continuously (optional feature)
//   spike_valid   : per-row one-cycle strobe
//   spike_addr    : per-row address, row r at [r*ADDR_WIDTH +: ADDR_WIDTH]
//   busy          : playback in progress
//   done          : one-cycle pulse with the last event of a non-looping pass
//   now           : current timebase (saturating)
//   count         : number of table entries loaded
//   late_count    : saturating count of events issued after their timestamp
//
// Optional feature: define SPIKE_EVENT_PLAYER_LOOP_EN to honour loop_en.
// Without it loop_en is ignored and every pass ends with done.
module spike_event_player #(
  parameter  int NUM_SYNAPSE_ROWS = 2,
  parameter  int ADDR_WIDTH       = 6,
  parameter  int TIME_WIDTH       = 16,
  parameter  int DEPTH            = 16,
  localparam int ROW_W            = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1,
  localparam int CNT_W            = $clog2(DEPTH) + 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   clear,
  spike_event_player_if.slave                    wr,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic                                   loop_en,
  output logic [NUM_SYNAPSE_ROWS-1:0]            spike_valid,
  output logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] spike_addr,
  output logic                                   busy,
  output logic                                   done,
  output logic [TIME_WIDTH-1:0]                  now,
  output logic [CNT_W-1:0]                       count,
  output logic [7:0]                             late_count
);

  localparam int             AW    = $clog2(DEPTH);
  localparam logic [ROW_W:0] NROWS = (ROW_W+1)'(NUM_SYNAPSE_ROWS);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e                                state_q, state_d;
  logic [CNT_W-1:0]                      count_q, count_d;
  logic [CNT_W-1:0]                      rd_ptr_q, rd_ptr_d;
  logic [TIME_WIDTH-1:0]                 now_q, now_d;
  logic [7:0]                            late_q, late_d;
  logic [NUM_SYNAPSE_ROWS-1:0]           valid_q, valid_d;
  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                                  done_q, done_d;

  // Event table; contents survive reset and clear, only count_q bounds it.
  logic [TIME_WIDTH-1:0] time_mem [DEPTH];
  logic [ROW_W-1:0]      row_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];

  logic                  wr_fire;
  logic [AW-1:0]         rd_idx;
  logic [TIME_WIDTH-1:0] cur_time;
  logic [ROW_W-1:0]      cur_row;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  issue, row_ok, last, loop_active;

`ifdef SPIKE_EVENT_PLAYER_LOOP_EN
  assign loop_active = loop_en;
`else
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
  assign loop_active    = 1'b0;
`endif

  assign wr.wr_ready = reset_n && (state_q == IDLE) && (count_q < CNT_W'(DEPTH)) && !clear;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;

  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign cur_time = time_mem[rd_idx];
  assign cur_row  = row_mem[rd_idx];
  assign cur_addr = addr_mem[rd_idx];

  // A stop in the same cycle suppresses the pending issue.
  assign issue  = (state_q == PLAY) && !stop && (rd_ptr_q < count_q) && (cur_time <= now_q);
  assign row_ok = {1'b0, cur_row} < NROWS;
  assign last   = (rd_ptr_q + CNT_W'(1)) == count_q;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      time_mem[count_q[AW-1:0]] <= wr.wr_time;
      row_mem[count_q[AW-1:0]]  <= wr.wr_row;
      addr_mem[count_q[AW-1:0]] <= wr.wr_addr;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    now_d    = now_q;
    late_d   = late_q;
    valid_d  = '0;
    addr_d   = addr_q;
    done_d   = 1'b0;

    // wr_ready already excludes clear and PLAY, so a write never races them.
    if (wr_fire) count_d = count_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (clear) begin
          count_d = '0;
          late_d  = '0;
        end else if (start && (count_q != '0)) begin
          state_d  = PLAY;
          now_d    = '0;
          rd_ptr_d = '0;
          late_d   = '0;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          now_d = (now_q == '1) ? now_q : now_q + TIME_WIDTH'(1);
          if (issue) begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
            // Out-of-range rows consume their slot silently.
            if (row_ok) begin
              for (int unsigned r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
                if (cur_row == ROW_W'(r)) begin
                  valid_d[r]                           = 1'b1;
                  addr_d[r*ADDR_WIDTH +: ADDR_WIDTH]   = cur_addr;
                end
              end
              if ((cur_time < now_q) && (late_q != 8'hFF)) late_d = late_q + 8'd1;
            end
            // Wrap for replay on the same edge as the last issue so the pass
            // period is exactly last timestamp + 1.
            if (last) begin
              if (loop_active) begin
                rd_ptr_d = '0;
                now_d    = '0;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      now_q    <= '0;
      late_q   <= '0;
      valid_q  <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      now_q    <= now_d;
      late_q   <= late_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
    end
  end

  assign spike_valid = valid_q;
  assign spike_addr  = addr_q;
  assign busy        = (state_q == PLAY);
  assign done        = done_q;
  assign now         = now_q;
  assign count       = count_q;
  assign late_count  = late_q;

endmodule

// File: tb/tb_spike_event_player.sv
module tb_spike_event_player;

  localparam int NR    = 3;
  localparam int AWD   = 6;
  localparam int TW    = 16;
  localparam int DEP   = 8;
  localparam int RW    = 2;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clear = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [NR-1:0]     spike_valid;
  logic [NR*AWD-1:0] spike_addr;
  logic              busy, done;
  logic [TW-1:0]     now;
  logic [CW-1:0]     count;
  logic [7:0]        late_count;

  spike_event_player_if #(.TIME_WIDTH(TW), .ROW_W(RW), .ADDR_WIDTH(AWD)) wr_if ();

  spike_event_player #(
    .NUM_SYNAPSE_ROWS(NR),
    .ADDR_WIDTH(AWD),
    .TIME_WIDTH(TW),
    .DEPTH(DEP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .wr(wr_if.slave),
    .start(start),
    .stop(stop),
    .loop_en(loop_en),
    .spike_valid(spike_valid),
    .spike_addr(spike_addr),
    .busy(busy),
    .done(done),
    .now(now),
    .count(count),
    .late_count(late_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference table and per-row "last address seen" model.
  int tt[DEP], rr[DEP], aa[DEP], cyc[DEP];
  int nent;
  int maddr[NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*AWD-1:0] pk();
    logic [NR*AWD-1:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) v[r*AWD +: AWD] = AWD'(maddr[r]);
    return v;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int t, input int r, input int a);
    wr_if.wr_time  = TW'(t);
    wr_if.wr_row   = RW'(r);
    wr_if.wr_addr  = AWD'(a);
    wr_if.wr_valid = 1'b1;
    #1;
    chk("wr_ready", wr_if.wr_ready, 1);
    next();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic load();
    clear = 1'b1;
    next();
    clear = 1'b0;
    for (int i = 0; i < nent; i++) wr(tt[i], rr[i], aa[i]);
    chk("count_loaded", count, nent);
  endtask

  // Each entry is examined at now = max(its timestamp, previous examine + 1);
  // its strobe is visible in the cycle after edge E + that value + 1.
  task automatic play();
    int prev, last, exp_late, mask;
    prev = -1;
    exp_late = 0;
    for (int i = 0; i < nent; i++) begin
      cyc[i] = (tt[i] > prev + 1) ? tt[i] : prev + 1;
      prev = cyc[i];
      if (rr[i] < NR && cyc[i] > tt[i]) exp_late++;
    end
    if (exp_late > 255) exp_late = 255;
    last = cyc[nent-1];
    start = 1'b1;
    next();
    start = 1'b0;
    for (int n = 1; n <= last + 2; n++) begin
      next();
      mask = 0;
      for (int i = 0; i < nent; i++) begin
        if (cyc[i] + 1 == n && rr[i] < NR) begin
          mask |= (1 << rr[i]);
          maddr[rr[i]] = aa[i];
        end
      end
      chk("spike_valid", spike_valid, mask);
      chk("spike_addr", spike_addr, pk());
      chk("done", done, (n == last + 1));
      chk("busy", busy, (n <= last));
      if (n <= last) chk("now", now, n);
    end
    chk("late_count", late_count, exp_late);
    chk("count_kept", count, nent);
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_time  = '0;
    wr_if.wr_row   = '0;
    wr_if.wr_addr  = '0;
    for (int r = 0; r < NR; r++) maddr[r] = 0;

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", spike_valid, 0);
    chk("rst_addr", spike_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_now", now, 0);
    chk("rst_count", count, 0);
    chk("rst_late", late_count, 0);
    chk("rst_wr_ready", wr_if.wr_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    next();
    chk("wr_ready_after_rst", wr_if.wr_ready, 1);

    // Three spaced events
    nent = 3;
    tt[0] = 50;  rr[0] = 1; aa[0] = 1;
    tt[1] = 100; rr[1] = 0; aa[1] = 2;
    tt[2] = 150; rr[2] = 1; aa[2] = 3;
    load();
    play();
    chk("late_zero", late_count, 0);

    // Equal timestamps: second one late by a cycle
    nent = 2;
    tt[0] = 10; rr[0] = 0; aa[0] = 4;
    tt[1] = 10; rr[1] = 1; aa[1] = 5;
    load();
    play();
    chk("late_equal_ts", late_count, 1);

    // Start with an empty table is ignored
    clear = 1'b1;
    next();
    clear = 1'b0;
    start = 1'b1;
    next();
    start = 1'b0;
    chk("empty_start_busy", busy, 0);
    next();
    chk("empty_start_busy2", busy, 0);

    // Fill to capacity, reject overflow, then clear
    nent = DEP;
    for (int i = 0; i < DEP; i++) begin
      tt[i] = i * 3; rr[i] = i % NR; aa[i] = 10 + i;
    end
    load();
    wr_if.wr_valid = 1'b1;
    #1;
    chk("full_wr_ready", wr_if.wr_ready, 0);
    next();
    wr_if.wr_valid = 1'b0;
    chk("full_count", count, DEP);
    play();
    clear = 1'b1;
    next();
    clear = 1'b0;
    #1;
    chk("clear_count", count, 0);
    chk("clear_wr_ready", wr_if.wr_ready, 1);
    clear = 1'b1;
    wr_if.wr_valid = 1'b1;
    next();
    clear = 1'b0;
    wr_if.wr_valid = 1'b0;
    chk("clear_beats_write", count, 0);

    // Randomized tables, including out-of-range rows and out-of-order stamps
    for (int it = 0; it < 6; it++) begin
      int prev;
      nent = $urandom_range(1, DEP);
      prev = 0;
      for (int i = 0; i < nent; i++) begin
        if ($urandom_range(0, 4) == 0) tt[i] = $urandom_range(0, prev);
        else                           tt[i] = prev + $urandom_range(0, 12);
        prev = tt[i];
        rr[i] = $urandom_range(0, 3);
        aa[i] = $urandom_range(0, 63);
      end
      load();
      play();
    end

    // Stop while waiting for the second event
    nent = 2;
    tt[0] = 50;  rr[0] = 0; aa[0] = 7;
    tt[1] = 100; rr[1] = 1; aa[1] = 9;
    load();
    start = 1'b1;
    next();
    start = 1'b0;
    for (int n = 1; n <= 130; n++) begin
      next();
      if (n == 51) maddr[0] = 7;
      chk("stop_valid", spike_valid, (n == 51) ? 1 : 0);
      chk("stop_done", done, 0);
      chk("stop_busy", busy, (n <= 60));
      if (n == 60) stop = 1'b1;
      if (n == 61) stop = 1'b0;
    end
    chk("stop_addr", spike_addr, pk());

    // Asynchronous reset during playback
    nent = 2;
    tt[0] = 5;   rr[0] = 2; aa[0] = 33;
    tt[1] = 200; rr[1] = 0; aa[1] = 1;
    load();
    start = 1'b1;
    next();
    start = 1'b0;
    repeat (10) next();
    maddr[2] = 33;
    chk("pre_rst_addr", spike_addr, pk());
    chk("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", spike_valid, 0);
    chk("arst_addr", spike_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_now", now, 0);
    chk("arst_count", count, 0);
    chk("arst_late", late_count, 0);
    chk("arst_wr_ready", wr_if.wr_ready, 0);
    for (int r = 0; r < NR; r++) maddr[r] = 0;
    @(negedge clk) reset_n = 1'b1;
    next();
    chk("post_rst_wr_ready", wr_if.wr_ready, 1);
    chk("post_rst_count", count, 0);

`ifdef SPIKE_EVENT_PLAYER_LOOP_EN
    // Loop replay: single event at T=3 repeats every 4 cycles
    nent = 1;
    tt[0] = 3; rr[0] = 1; aa[0] = 21;
    load();
    loop_en = 1'b1;
    start = 1'b1;
    next();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      next();
      chk("loop_valid", spike_valid, (n % 4 == 0) ? 2 : 0);
      chk("loop_done", done, 0);
      chk("loop_busy", busy, 1);
    end
    stop = 1'b1;
    next();
    stop = 1'b0;
    loop_en = 1'b0;
    chk("loop_stop_busy", busy, 0);
    chk("loop_stop_done", done, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
